// File: rtl/fft_pkg.sv
// FFT shared package: frame geometry, bit reversal
// and the complex sample type.
package fft_pkg;

  localparam int FFT_N      = 512;
  localparam int FFT_NUM    = 16;
  localparam int FFT_BEATS  = 32;
  localparam int FFT_LOG2N  = 9;
  localparam int FFT_BEAT_W = 5;
  localparam int FFT_WIDTH  = 23;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } fft_cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev9(
    input logic [FFT_LOG2N-1:0] x
  );
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++)
      r[i] = x[FFT_LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream bundle of the output reorder buffer:
// bit-reversed input beats in, natural beats out.
interface fft_out_reorder_if #(
  parameter int WIDTH = 23,
  parameter int NUM   = 16
);
  logic                    valid_in;
  logic signed [WIDTH-1:0] din_re [NUM];
  logic signed [WIDTH-1:0] din_im [NUM];
  logic signed [WIDTH-1:0] dout_re [NUM];
  logic signed [WIDTH-1:0] dout_im [NUM];
  logic                    valid_out;
  logic                    frame_err;

  modport master (
    output valid_in, din_re, din_im,
    input  dout_re, dout_im, valid_out, frame_err
  );

  modport slave (
    input  valid_in, din_re, din_im,
    output dout_re, dout_im, valid_out, frame_err
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// One 512-entry complex store: scattered 16-wide
// writes by natural bin, 16-wide natural beat reads.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = 23
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [FFT_BEAT_W-1:0]   wr_beat,
  input  logic signed [WIDTH-1:0] wr_re [FFT_NUM],
  input  logic signed [WIDTH-1:0] wr_im [FFT_NUM],
  input  logic [FFT_BEAT_W-1:0]   rd_beat,
  output logic signed [WIDTH-1:0] rd_re [FFT_NUM],
  output logic signed [WIDTH-1:0] rd_im [FFT_NUM]
);

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } smp_t;

  smp_t mem [FFT_N];

  // Each lane lands at its natural bin index.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < FFT_NUM; l++)
        mem[bitrev9({wr_beat, 4'(l)})] <=
          '{wr_re[l], wr_im[l]};
    end
  end

  // A natural beat is 16 consecutive bins.
  always_comb begin
    for (int l = 0; l < FFT_NUM; l++) begin
      rd_re[l] = mem[{rd_beat, 4'(l)}].re;
      rd_im[l] = mem[{rd_beat, 4'(l)}].im;
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer: ping-pong banks turn
// bit-reversed frames into natural-order frames.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int NUM   = FFT_NUM,
  parameter int N     = FFT_N,
  parameter int BEATS = FFT_BEATS
) (
  input logic              clk,
  input logic              rstn,
  fft_out_reorder_if.slave io
);

  localparam int BW = $clog2(N / NUM);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  logic [BW-1:0] wr_beat;
  logic          wr_bank;
  logic          wr_last;
  logic          wr_adv;
  logic          abort;

  rd_state_e     state;
  rd_state_e     state_nxt;
  logic [BW-1:0] rd_beat;
  logic          rd_bank;
  logic          pend;
  logic          pend_bank;
  logic          rd_last;
  logic          have_next;
  logic          next_bank;
  logic          rd_en;
  logic          rd_load;

  logic signed [WIDTH-1:0] b0_re [NUM];
  logic signed [WIDTH-1:0] b0_im [NUM];
  logic signed [WIDTH-1:0] b1_re [NUM];
  logic signed [WIDTH-1:0] b1_im [NUM];

  assign wr_last = io.valid_in && (wr_beat == LAST);
  assign wr_adv  = io.valid_in && (wr_beat != LAST);
  assign abort   = !io.valid_in && (wr_beat != '0);

  assign rd_last   = (state == RD_READ) &&
                     (rd_beat == LAST);
  assign have_next = wr_last || pend;
  assign next_bank = pend ? pend_bank : wr_bank;

  fft_reorder_bank #(.WIDTH(WIDTH)) u_bank0 (
    .clk     (clk),
    .we      (io.valid_in && !wr_bank),
    .wr_beat (wr_beat),
    .wr_re   (io.din_re),
    .wr_im   (io.din_im),
    .rd_beat (rd_beat),
    .rd_re   (b0_re),
    .rd_im   (b0_im)
  );

  fft_reorder_bank #(.WIDTH(WIDTH)) u_bank1 (
    .clk     (clk),
    .we      (io.valid_in && wr_bank),
    .wr_beat (wr_beat),
    .wr_re   (io.din_re),
    .wr_im   (io.din_im),
    .rd_beat (rd_beat),
    .rd_re   (b1_re),
    .rd_im   (b1_im)
  );

  // Write beat count, bank flip on hand-over, abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_beat      <= '0;
      wr_bank      <= 1'b0;
      io.frame_err <= 1'b0;
    end else begin
      io.frame_err <= abort;
      unique case (1'b1)
        wr_last: begin
          wr_beat <= '0;
          wr_bank <= ~wr_bank;
        end
        wr_adv:  wr_beat <= wr_beat + BW'(1);
        abort:   wr_beat <= '0;
        default: ;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RD_IDLE;
    else       state <= state_nxt;
  end

  // Read FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RD_IDLE: if (wr_last) state_nxt = RD_READ;
      RD_READ: if (rd_last && !have_next)
                 state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM outputs: emit enable and bank load.
  always_comb begin
    rd_en   = 1'b0;
    rd_load = 1'b0;
    unique case (state)
      RD_IDLE: rd_load = wr_last;
      RD_READ: begin
        rd_en   = 1'b1;
        rd_load = rd_last && have_next;
      end
      default: ;
    endcase
  end

  // Read beat, active bank and pending bank flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_beat   <= '0;
      rd_bank   <= 1'b0;
      pend      <= 1'b0;
      pend_bank <= 1'b0;
    end else begin
      if (rd_en)
        rd_beat <= rd_last ? '0 : rd_beat + BW'(1);
      if (rd_load)
        rd_bank <= next_bank;
      if (wr_last && rd_en && !rd_last) begin
        pend      <= 1'b1;
        pend_bank <= wr_bank;
      end else if (rd_load) begin
        pend <= 1'b0;
      end
    end
  end

  // Registered outputs; data holds while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io.valid_out <= 1'b0;
      for (int l = 0; l < NUM; l++) begin
        io.dout_re[l] <= '0;
        io.dout_im[l] <= '0;
      end
    end else begin
      io.valid_out <= rd_en;
      if (rd_en) begin
        for (int l = 0; l < NUM; l++) begin
          io.dout_re[l] <= rd_bank ? b1_re[l] : b0_re[l];
          io.dout_im[l] <= rd_bank ? b1_im[l] : b0_im[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: natural-order frame
// model with cycle-exact output and error schedule.
module tb_fft_out_reorder;

  localparam int W = 23;
  localparam int L = 16;
  localparam int MINV = -(1 << (W - 1));
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int SENT = -1234567;

  typedef logic signed [W-1:0] smp_t;

  typedef struct {
    int   due;
    smp_t re [L];
    smp_t im [L];
  } obeat_t;

  typedef struct {
    int f;
    int r;
    int l;
    int re;
    int im;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.WIDTH(W), .NUM(L)) io ();

  fft_out_reorder #(
    .WIDTH (W),
    .NUM   (L),
    .N     (512),
    .BEATS (32)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io)
  );

  obeat_t expq [$];
  int     err_due [$];
  smp_t   src_re [512];
  smp_t   src_im [512];
  smp_t   cap_re [8][512];
  smp_t   cap_im [8][512];
  int     m_beat = 0;
  int     cyc = 0;
  int     n_out = 0;
  int     checks = 0;
  int     errors = 0;
  vec_t   tv [12];

  function automatic int rev9(int x);
    int r = 0;
    for (int i = 0; i < 9; i++)
      r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Cycle-exact comparison against the model queues.
  always @(negedge clk) begin : mon
    obeat_t e;
    bit ev;
    bit ee;
    int bad;
    if (rstn) begin
      ev = (expq.size() != 0) && (expq[0].due == cyc);
      if (ev || io.valid_out) begin
        checks++;
        if (ev != io.valid_out) begin
          errors++;
          $display("FAIL valid_out cyc %0d got %0b exp %0b",
                   cyc, io.valid_out, ev);
          if (ev) void'(expq.pop_front());
        end else begin
          e = expq.pop_front();
          bad = -1;
          for (int l = 0; l < L; l++)
            if (bad < 0 && (io.dout_re[l] !== e.re[l] ||
                            io.dout_im[l] !== e.im[l]))
              bad = l;
          if (bad >= 0) begin
            errors++;
            $display("FAIL dout cyc %0d lane %0d got %0d/%0d exp %0d/%0d",
                     cyc, bad, io.dout_re[bad], io.dout_im[bad],
                     e.re[bad], e.im[bad]);
          end
        end
      end
      if (io.valid_out) begin
        if (n_out / 32 < 8)
          for (int l = 0; l < L; l++) begin
            cap_re[n_out/32][(n_out%32)*L+l] = io.dout_re[l];
            cap_im[n_out/32][(n_out%32)*L+l] = io.dout_im[l];
          end
        n_out++;
      end
      ee = (err_due.size() != 0) && (err_due[0] == cyc);
      if (ee || io.frame_err) begin
        checks++;
        if (ee) void'(err_due.pop_front());
        if (ee != io.frame_err) begin
          errors++;
          $display("FAIL frame_err cyc %0d got %0b exp %0b",
                   cyc, io.frame_err, ee);
        end
      end
    end
  end

  task automatic fill(int mode, int base);
    for (int k = 0; k < 512; k++) begin
      case (mode)
        0: begin
          src_re[k] = smp_t'(k + base);
          src_im[k] = smp_t'(-(k + base));
        end
        1: begin
          src_re[k] = smp_t'(3 * k);
          src_im[k] = smp_t'(k - 100);
        end
        2: begin
          src_re[k] = smp_t'(1000 - k);
          src_im[k] = smp_t'(k);
        end
        default: begin
          src_re[k] = smp_t'($urandom);
          src_im[k] = smp_t'($urandom);
        end
      endcase
    end
  endtask

  task automatic drive_beat();
    int b;
    @(negedge clk);
    b = m_beat;
    io.valid_in = 1'b1;
    for (int l = 0; l < L; l++) begin
      io.din_re[l] = src_re[rev9(b * L + l)];
      io.din_im[l] = src_im[rev9(b * L + l)];
    end
    m_beat++;
    if (m_beat == 32) begin
      m_beat = 0;
      for (int r = 0; r < 32; r++) begin
        obeat_t e;
        e.due = cyc + 2 + r;
        for (int l = 0; l < L; l++) begin
          e.re[l] = src_re[r * L + l];
          e.im[l] = src_im[r * L + l];
        end
        expq.push_back(e);
      end
    end
  endtask

  task automatic idle_beat();
    @(negedge clk);
    io.valid_in = 1'b0;
    for (int l = 0; l < L; l++) begin
      io.din_re[l] = smp_t'($urandom);
      io.din_im[l] = smp_t'($urandom);
    end
    if (m_beat != 0) begin
      err_due.push_back(cyc + 1);
      m_beat = 0;
    end
  endtask

  task automatic send_frame();
    repeat (32) drive_beat();
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 200; i++)
      if (expq.size() != 0 || err_due.size() != 0)
        idle_beat();
    chk(nm, expq.size() + err_due.size(), 0);
  endtask

  task automatic chk_zero(string nm);
    int nz = 0;
    for (int l = 0; l < L; l++)
      if (io.dout_re[l] != 0 || io.dout_im[l] != 0)
        nz++;
    chk({nm, "_valid"}, int'(io.valid_out), 0);
    chk({nm, "_ferr"}, int'(io.frame_err), 0);
    chk({nm, "_dout_nz"}, nz, 0);
  endtask

  initial begin
    tv[0]  = '{0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 15, 15, -15};
    tv[2]  = '{0, 16, 3, 259, -259};
    tv[3]  = '{0, 31, 15, 511, -511};
    tv[4]  = '{1, 31, 15, 511, -511};
    tv[5]  = '{2, 0, 0, 512, -512};
    tv[6]  = '{2, 31, 15, 1023, -1023};
    tv[7]  = '{3, 5, 7, 261, -13};
    tv[8]  = '{5, 2, 2, 966, 34};
    tv[9]  = '{6, 0, 0, MINV, MAXV};
    tv[10] = '{6, 31, 15, MAXV, MINV};
    tv[11] = '{6, 10, 1, 161, -161};

    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 512; k++) begin
        cap_re[f][k] = smp_t'(SENT);
        cap_im[f][k] = smp_t'(SENT);
      end
    io.valid_in = 1'b0;
    for (int l = 0; l < L; l++) begin
      io.din_re[l] = '0;
      io.din_im[l] = '0;
    end

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Frame 0: identity-style ramp.
    fill(0, 0);
    send_frame();
    drain("drain_f0");
    chk("hold_re15", int'(io.dout_re[15]), 511);
    chk("hold_im0", int'(io.dout_im[0]), -496);

    // Frames 1 and 2 back-to-back.
    fill(0, 0);
    send_frame();
    fill(0, 512);
    send_frame();
    drain("drain_b2b");

    // Abort after 10 beats, then frame 3.
    fill(3, 0);
    repeat (10) drive_beat();
    idle_beat();
    fill(1, 0);
    send_frame();
    drain("drain_abort");

    // Frame 4 cut by reset at output beat 5.
    fill(3, 0);
    send_frame();
    repeat (7) idle_beat();
    #1 rstn = 1'b0;
    #1 chk_zero("midrst");
    expq.delete();
    err_due.delete();
    m_beat = 0;
    n_out = (n_out + 31) / 32 * 32;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) idle_beat();

    // Frame 5 after reset.
    fill(2, 0);
    send_frame();
    drain("drain_rst");

    // Frame 6: extreme values at bins 0 and 511.
    fill(0, 0);
    src_re[0]   = smp_t'(MINV);
    src_im[0]   = smp_t'(MAXV);
    src_re[511] = smp_t'(MAXV);
    src_im[511] = smp_t'(MINV);
    send_frame();
    drain("drain_ext");

    // Random frames, gaps and aborts.
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(3) == 0) begin
        fill(3, 0);
        repeat ($urandom_range(31, 1)) drive_beat();
        idle_beat();
      end
      fill(3, 0);
      send_frame();
      repeat ($urandom_range(2)) idle_beat();
    end
    drain("drain_rand");

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tv%0d_re", i),
          int'(cap_re[tv[i].f][tv[i].r * L + tv[i].l]),
          tv[i].re);
      chk($sformatf("tv%0d_im", i),
          int'(cap_im[tv[i].f][tv[i].r * L + tv[i].l]),
          tv[i].im);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

- Output reorder buffer at the tail of the 512-point, 16-lane pipelined FFT.
- Accepts one frame of 512 complex results as 32 beats × 16 lanes in bit-reversed index order, then emits the same frame in natural order, 16 samples per beat.
- Uses a two-bank ping-pong store, so back-to-back frames stream with no gaps and no backpressure.
- Sits after the last butterfly/twiddle stage; it is the consumer of the stage outputs (`do*_re/im`, `valid_out`).

## Interface
Parameters:
- `WIDTH`, 23: signed sample width, re and im (matches the upstream stage output width).
- `NUM`, 16: lanes per beat.
- `N`, 512: points per frame.
- `BEATS`, `N/NUM` = 32: beats per frame.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset; asynchronous, active-low.
- `valid_in`, in, 1: input beat qualifier.
- `din_re`, in, `signed [WIDTH-1:0] [0:NUM-1]`: real parts, bit-reversed order.
- `din_im`, in, `signed [WIDTH-1:0] [0:NUM-1]`: imaginary parts, bit-reversed order.
- `dout_re`, out, `signed [WIDTH-1:0] [0:NUM-1]`: real parts, natural order.
- `dout_im`, out, `signed [WIDTH-1:0] [0:NUM-1]`: imaginary parts, natural order.
- `valid_out`, out, 1: output beat qualifier.
- `frame_err`, out, 1: one-cycle pulse when a frame is aborted.

## Operation
Index mapping:
- Input beat `b` (0..31), lane `l` carries FFT bin `k = bitrev9(b*16 + l)`.
- Output beat `r`, lane `l` carries bin `r*16 + l`.
- Data values pass through unchanged: no scaling, rounding or saturation.

Write side:
- Counter `wr_beat` (0..31) advances on each `valid_in=1` cycle.
- Each beat is stored into the current write bank.
- When beat 31 is written, the write bank is marked full and handed to the read side, and `wr_bank` toggles.

Abort:
- `valid_in=0` while `0 < wr_beat < 32` aborts the frame.
- `wr_beat` returns to 0, the partial bank is discarded (not handed over), and `frame_err` pulses for one cycle.
- Idle `valid_in=0` with `wr_beat=0` is legal and produces no error.

Read side:
- Two states: IDLE and READ.
- IDLE → READ on the hand-over of a full bank.
- READ emits beats `r` = 0..31 from that bank.
- At `r=31`:
  - if another full bank was handed over, stay in READ and continue with `r=0` of the new bank;
  - otherwise go to IDLE.
- Hand-over and the last read beat in the same cycle is the normal back-to-back case. The read of the old bank completes and the new bank is read next, seamlessly.
- A bank is never overwritten while it is being read. Write and read rates are equal, so at most one bank is ever pending.

Reset:
- Asynchronous; may occur mid-frame or mid-read.
- Clears all counters, bank flags and the state (IDLE).
- Pending and partial data is discarded.
- Stored sample contents need not be cleared.

## Timing
Reset values:
- `valid_out=0`.
- All `dout_re`/`dout_im` lanes = 0.
- `frame_err=0`.

Output registering and latency:
- Outputs are registered.
- Final input beat captured at edge E → output beat 0 appears after edge E+1, beat 31 after edge E+32.
- `valid_out` is high for exactly 32 consecutive cycles per frame.
- Latency from the first input beat to the first output beat is 32 cycles.

Other timing:
- Continuous input with frames back-to-back gives continuous `valid_out` with no bubble.
- `dout` holds its last value when `valid_out=0`.
- `frame_err` is asserted in the cycle after the aborting `valid_in=0` sample.

## Structure
- Shared package `fft_pkg`:
  - constants `FFT_N=512`, `FFT_NUM=16`, `FFT_BEATS=32`, `FFT_LOG2N=9`;
  - function `bitrev9`;
  - complex-sample typedef parameterised by width.
- Sub-module `fft_reorder_bank`: one 512-entry complex store.
  - 16-wide write port, addressed by natural bin index.
  - 16-wide read port, addressed by natural beat.
  - Instantiated twice for ping-pong.
- Top level contains the write counter, abort logic, bank flags and the read FSM.

## Test plan
- Single frame, input `re = bitrev9(b*16+l)`, `im = -re` → output beat r lane l gives `re = r*16+l`, `im = -(r*16+l)`. Beat 0 = 0..15, beat 31 lane 15 = 511. `valid_out` high exactly 32 cycles, starting 1 cycle after the last input beat.
- Two frames back-to-back, frame 2 values offset by +512 → `valid_out` high 64 continuous cycles. Frame 2 beat 0 lane 0 = 512; last lane = 1023.
- `valid_in` dropped after 10 beats, then a full frame → `frame_err` pulses once, no output for the partial frame, and the full frame is reordered correctly.
- `rstn` asserted during output beat 5 → `valid_out`, `dout` and `frame_err` go to 0 immediately. No further output until a new complete frame is supplied.
- Extreme values: bins 0 and 511 carry `-2^(WIDTH-1)` and `2^(WIDTH-1)-1` in re and im → those values appear bit-exact at output beat 0 lane 0 and beat 31 lane 15.
